// File: rtl/vdp_defs.sv
// Shared video-datapath definitions: FSM state encodings and the default
// geometry used by the frame-store memory, the frame reader and the display stage.
package vdp_defs;

  localparam int DW_DEF = 32;  // memory word width
  localparam int AW_DEF = 4;   // memory address width (16-word frame)
  localparam int PW_DEF = 4;   // pixel width

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/px_shifter.sv
// Word-to-pixel serializer: holds one memory word and emits it PW bits at a
// time, least significant pixel first, while tracking the pixel index.
module px_shifter #(
  parameter int DW = 32,
  parameter int PW = 4
) (
  input  logic          c,
  input  logic          rst,
  input  logic          load,
  input  logic          shift,
  input  logic [DW-1:0] d,
  output logic [PW-1:0] px,
  output logic          last
);

  localparam int NPX = DW / PW;
  localparam int CW  = (NPX > 1) ? $clog2(NPX) : 1;

  logic [DW-1:0] shreg_q, shreg_d;
  logic [CW-1:0] pc_q, pc_d;

  // Next state: a load restarts the word, a shift drops the accepted pixel.
  always_comb begin
    shreg_d = shreg_q;
    pc_d    = pc_q;
    if (load) begin
      shreg_d = d;
      pc_d    = '0;
    end else if (shift) begin
      shreg_d = shreg_q >> PW;
      pc_d    = pc_q + CW'(1);
    end
  end

  // Register the shift register and pixel counter.
  always_ff @(posedge c) begin
    if (rst) begin
      shreg_q <= '0;
      pc_q    <= '0;
    end else begin
      shreg_q <= shreg_d;
      pc_q    <= pc_d;
    end
  end

  assign px   = shreg_q[PW-1:0];
  assign last = (pc_q == CW'(NPX - 1));

endmodule

// File: rtl/frame_reader.sv
// Frame reader: on start, fetches words 0..2^AW-1 from the frame store one at
// a time and streams their pixels out over a valid/ready handshake.
module frame_reader
  import vdp_defs::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int PW = PW_DEF
) (
  input  logic          c,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          ld,
  output logic [AW-1:0] a,
  input  logic [DW-1:0] d,
  output logic [PW-1:0] px,
  output logic          px_valid,
  input  logic          px_ready,
  output logic          frame_done
);

  localparam logic [AW-1:0] WI_LAST = '1;

  state_e        state_q;
  logic [AW-1:0] wi_q;
  logic [AW-1:0] a_q;
  logic          busy_q, ld_q, px_valid_q, frame_done_q;
  logic          accept, last;

  // A pixel leaves only on a handshake; px_valid_q is high only in SHIFT.
  assign accept = px_valid_q & px_ready;

  px_shifter #(
    .DW(DW),
    .PW(PW)
  ) u_shifter (
    .c    (c),
    .rst  (rst),
    .load (state_q == ST_FETCH),
    .shift(accept),
    .d    (d),
    .px   (px),
    .last (last)
  );

  // Frame sequencing FSM with registered memory strobe, address and status outputs.
  always_ff @(posedge c) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wi_q         <= '0;
      a_q          <= '0;
      busy_q       <= 1'b0;
      ld_q         <= 1'b0;
      px_valid_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ld_q         <= 1'b0;
          frame_done_q <= 1'b0;
          if (start) begin
            state_q <= ST_FETCH;
            wi_q    <= '0;
            a_q     <= '0;
            ld_q    <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        ST_FETCH: begin
          // The word is captured by the shifter at this edge.
          ld_q       <= 1'b0;
          px_valid_q <= 1'b1;
          state_q    <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (accept && last) begin
            px_valid_q <= 1'b0;
            if (wi_q == WI_LAST) begin
              state_q      <= ST_DONE;
              frame_done_q <= 1'b1;
            end else begin
              wi_q    <= wi_q + 1'b1;
              a_q     <= wi_q + 1'b1;
              ld_q    <= 1'b1;
              state_q <= ST_FETCH;
            end
          end
        end
        ST_DONE: begin
          // Park the address at 0 so the idle bus points at the frame start.
          frame_done_q <= 1'b0;
          busy_q       <= 1'b0;
          a_q          <= '0;
          state_q      <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign ld         = ld_q;
  assign a          = a_q;
  assign px_valid   = px_valid_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_frame_reader.sv
// Self-checking bench for frame_reader: a frame-store model answers reads, a
// reference pixel list is computed from the stored words, and every accepted
// pixel, memory strobe and frame pulse is compared against it.
`timescale 1ns/1ps
module tb_frame_reader;

  localparam int DW  = 32;
  localparam int AW  = 4;
  localparam int PW  = 4;
  localparam int NW  = 16;
  localparam int NPX = 8;
  localparam int NPIX = NW * NPX;

  logic          c = 1'b0;
  logic          rst, start, px_ready;
  logic [DW-1:0] d;
  logic          busy, ld, px_valid, frame_done;
  logic [AW-1:0] a;
  logic [PW-1:0] px;

  logic [31:0] mem [NW];
  logic [31:0] junk;

  int total = 0;
  int bad   = 0;

  frame_reader #(.DW(DW), .AW(AW), .PW(PW)) dut (
    .c         (c),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .ld        (ld),
    .a         (a),
    .d         (d),
    .px        (px),
    .px_valid  (px_valid),
    .px_ready  (px_ready),
    .frame_done(frame_done)
  );

  always #5 c = ~c;

  // Frame store: valid data only while read-enabled, garbage otherwise.
  always_comb d = ld ? mem[a] : junk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Pixel n of the frame is nibble (n mod 8) of word (n div 8).
  function automatic logic [31:0] exp_px(input int n);
    logic [31:0] w;
    w = mem[n / NPX];
    return (w >> (PW * (n % NPX))) & 32'hF;
  endfunction

  function automatic logic ready_for(input int mode, input int cyc);
    case (mode)
      1:       return (cyc % 4 == 0) || (cyc % 4 == 3);
      3:       return !(cyc >= 2 && cyc <= 21);
      4:       return 1'($urandom_range(0, 1));
      default: return 1'b1;
    endcase
  endfunction

  // mode 0: ready=1, 1: 1,0,0,1 pattern, 2: extra starts, 3: long first stall, 4: random ready
  task automatic run_frame(input int mode);
    int   cyc, ld_cnt, pix_cnt, done_cnt, done_cyc;
    logic prev_ld, stalled, finished;
    logic [PW-1:0] held;
    ld_cnt = 0; pix_cnt = 0; done_cnt = 0; done_cyc = 0;
    prev_ld = 1'b0; stalled = 1'b0; finished = 1'b0; held = '0;
    @(negedge c);
    start = 1'b1;
    px_ready = ready_for(mode, 0);
    @(negedge c);
    start = 1'b0;
    cyc = 1;
    check("start_busy", 32'(busy), 32'd1);
    check("start_ld",   32'(ld),   32'd1);
    check("start_a",    32'(a),    32'd0);
    while (!finished && cyc < 3000) begin
      junk = ($urandom_range(0, 3) == 0) ? 'x : $urandom;
      px_ready = ready_for(mode, cyc);
      if (mode == 2) start = (cyc == 5 || cyc == 50);
      if (stalled) begin
        check("stall_valid", 32'(px_valid), 32'd1);
        check("stall_px",    32'(px),       32'(held));
      end
      if (ld) begin
        check("ld_addr",   32'(a),       32'(ld_cnt));
        check("ld_single", 32'(prev_ld), 32'd0);
        ld_cnt++;
      end
      if (mode == 3 && cyc >= 2 && cyc <= 21) begin
        check("hold_valid",  32'(px_valid), 32'd1);
        check("hold_px",     32'(px),       32'd0);
        check("hold_noload", 32'(ld),       32'd0);
      end
      if (px_valid && px_ready) begin
        if (pix_cnt < NPIX) check("pixel", 32'(px), exp_px(pix_cnt));
        pix_cnt++;
      end
      stalled = px_valid && !px_ready;
      held    = px;
      if (frame_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (done_cnt > 0 && cyc == done_cyc + 1) begin
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_a",    32'(a),    32'd0);
        check("idle_ld",   32'(ld),   32'd0);
      end
      if (done_cnt > 0 && cyc == done_cyc + 3) finished = 1'b1;
      prev_ld = ld;
      @(negedge c);
      cyc++;
    end
    start = 1'b0;
    check("frame_finished", 32'(finished), 32'd1);
    check("pixel_count",    32'(pix_cnt),  32'(NPIX));
    check("ld_count",       32'(ld_cnt),   32'(NW));
    check("done_count",     32'(done_cnt), 32'd1);
    if (mode == 0) check("done_cycle", 32'(done_cyc), 32'd145);
    $display("frame mode=%0d pixels=%0d ld=%0d done_at=%0d", mode, pix_cnt, ld_cnt, done_cyc);
  endtask

  task automatic reset_mid_frame();
    @(negedge c);
    start = 1'b1;
    px_ready = 1'b1;
    @(negedge c);
    start = 1'b0;
    repeat (39) @(negedge c);
    rst = 1'b1;
    @(negedge c);
    check("rst_ld",       32'(ld),         32'd0);
    check("rst_a",        32'(a),          32'd0);
    check("rst_valid",    32'(px_valid),   32'd0);
    check("rst_busy",     32'(busy),       32'd0);
    check("rst_done",     32'(frame_done), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge c);
      check("post_rst_done", 32'(frame_done), 32'd0);
      check("post_rst_ld",   32'(ld),         32'd0);
    end
    $display("reset mid-frame applied at cycle 40");
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; px_ready = 1'b0; junk = '0;
    for (int i = 0; i < NW; i++) mem[i] = 32'h7654_3210 + 32'(i) * 32'h1111_1111;
    repeat (3) @(negedge c);
    rst = 1'b0;
    check("reset_busy",  32'(busy),       32'd0);
    check("reset_ld",    32'(ld),         32'd0);
    check("reset_a",     32'(a),          32'd0);
    check("reset_px",    32'(px),         32'd0);
    check("reset_valid", 32'(px_valid),   32'd0);
    check("reset_done",  32'(frame_done), 32'd0);

    run_frame(0);
    run_frame(1);
    run_frame(2);
    run_frame(3);
    reset_mid_frame();
    run_frame(0);

    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < NW; i++) mem[i] = $urandom;
      run_frame(4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_reader.md
# frame_reader

Downstream consumer of the 16×32 frame-store memory. On a `start` pulse it sweeps memory addresses 0–15 once, driving the memory's read enable and address. It captures each 32-bit word and serializes it into a pixel stream with a valid/ready handshake. This stream feeds the display output stage. The block never drives the memory's write enable. The writer side must keep `str` low while a frame read is in progress.

## Interface
Parameters:
- `DW`, 32, memory word width
- `AW`, 4, memory address width; frame length is 2^AW = 16 words
- `PW`, 4, pixel width in bits; must divide `DW`, giving `DW/PW` = 8 pixels per word

Ports:
- `c`  in  1  clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  one-cycle request to read one frame
- `busy`  out  1  high from the cycle after `start` is accepted until `frame_done`
- `ld`  out  1  memory read enable; registered
- `a`  out  AW  memory address; registered
- `d`  in  DW  memory read data; only meaningful while `ld`=1 (high-Z otherwise)
- `px`  out  PW  current pixel
- `px_valid`  out  1  `px` holds a valid pixel
- `px_ready`  in  1  downstream accepts `px` at this edge
- `frame_done`  out  1  one-cycle pulse after the last pixel is accepted

## Operation
- FSM states are IDLE, FETCH, SHIFT, DONE.
- IDLE: `busy`=0, `ld`=0. When `start`=1, move to FETCH with word index `wi`=0.
- FETCH lasts exactly one cycle, with `ld`=1 and `a`=`wi`.
  - At the closing edge, load `d` into the shift register.
  - Clear the pixel counter `pc`.
  - Move to SHIFT.
- SHIFT: `px_valid`=1, `ld`=0, and `px` = shreg[PW-1:0], so pixels go out LSB first.
  - On each edge with `px_valid`&`px_ready`: shift shreg right by PW and increment `pc`.
  - If the pixel just accepted was the last one of the word (`pc` = DW/PW−1):
    - if `wi` = 2^AW−1, go to DONE;
    - otherwise increment `wi` and go to FETCH.
- DONE lasts one cycle with `frame_done`=1. Then return to IDLE with `busy`=0.
- `d` is sampled only at the edge that ends a FETCH cycle. A `d` value of X or Z at any other time has no effect.
- `start` is ignored while `busy`=1.
- Width rules:
  - `wi` is AW bits and does not overflow; DONE is taken before it would wrap.
  - `pc` is clog2(DW/PW) bits.
  - After the frame, `a` returns to 0 in IDLE.

## Timing
- Reset values: `busy`=0, `ld`=0, `a`=0, `px`=0, `px_valid`=0, `frame_done`=0; state is IDLE.
- Reset mid-frame aborts the frame on the next edge. It produces no `frame_done` and leaves `ld` low.
- Start timing:
  - `start` is sampled at edge k.
  - During cycle k+1: `ld`=1, `a`=0, `busy`=1.
  - During cycle k+2: `px_valid`=1 with the first pixel.
- Each word costs one FETCH bubble, during which `px_valid`=0.
- With `px_ready` held at 1, a frame takes 16×(1+8) = 144 cycles from FETCH start to DONE. `frame_done` is asserted in cycle 145 after `start`.
- Handshake rules:
  - While `px_valid`=1 and `px_ready`=0, `px` and `px_valid` hold stable.
  - `px_valid` never drops without an accepting handshake, except on reset.
- `ld` is high for exactly one cycle per word, 16 pulses per frame. `a` changes only on edges that enter FETCH.
- `start` asserted in the DONE cycle is ignored. A new frame needs `start` in IDLE.

## Structure
- Shared package/include `vdp_defs` holds:
  - FSM state encodings (2-bit: IDLE=0, FETCH=1, SHIFT=2, DONE=3);
  - default `DW`/`AW`/`PW` constants, shared with the memory and the display stage.
- Natural sub-module: `px_shifter`. It contains the DW-bit load/shift register plus `pc`, with inputs load, shift and d, and outputs px and last.
- The top level holds the FSM, `wi`, and the registered `ld`/`a`.

## Test plan
- Preload mem[i] = 32'h7654_3210 + i×32'h1111_1111; `start`, `px_ready`=1 → 128 pixels arrive. Word 0 gives 0,1,…,7; word 1 gives 1,2,…,8 (nibbles of 32'h8765_4321). `frame_done` pulses in cycle 145 after `start`. `ld` pulses 16 times with `a` = 0..15.
- `px_ready` toggles 1,0,0,1 repeatedly → same pixel sequence. `px` is stable during every stall, and no pixel is dropped or duplicated.
- `start` reasserted at cycles 5 and 50 of a frame → ignored; exactly one `frame_done`; 128 pixels.
- `rst` asserted at cycle 40 mid-frame → next edge: `ld`=0, `a`=0, `px_valid`=0, `busy`=0, no `frame_done`. A subsequent `start` delivers a full frame starting with pixel 0 of mem[0].
- Memory bus driven to Z/X whenever `ld`=0 → output pixels unaffected. Also check that `ld` is never high for two consecutive cycles.
- `px_ready`=0 held for 20 cycles at the first pixel → `px`=0 and `px_valid`=1 held for 20 cycles, no `ld` pulse during the stall.
